// File: rtl/hazard_if.sv
// Decode-side hazard bundle: issue request, redirect and data-memory status in,
// stall/flush/freeze controls out.
interface hazard_if #(
  parameter int REG_AW = 5
);
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic              issue_rs_used;
  logic              issue_rt_used;
  logic              issue_wen;
  logic [REG_AW-1:0] issue_dest;
  logic              issue_is_load;
  logic              branch_taken;
  logic              jump;
  logic              dmemREN;
  logic              dmemWEN;
  logic              dhit;
  logic              stall;
  logic              flush;
  logic              freeze;
  logic              hazard;
  logic [1:0]        state;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
           issue_wen, issue_dest, issue_is_load, branch_taken, jump,
           dmemREN, dmemWEN, dhit,
    input  stall, flush, freeze, hazard, state
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
           issue_wen, issue_dest, issue_is_load, branch_taken, jump,
           dmemREN, dmemWEN, dhit,
    output stall, flush, freeze, hazard, state
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard with countdown counters, sequenced branch/jump flush and
// dcache-miss freeze FSM. Build option FORWARD_EN: forwarded ALU results, short load-use.
module hazard_scoreboard #(
  parameter int NREGS        = 32,
  parameter int REG_AW       = 5,
  parameter int LAT_W        = 2,
  parameter int ALU_LAT      = 3,
  parameter int LOAD_LAT     = 3,
  parameter int LOAD_FWD_LAT = 1,
  parameter int FLUSH_CYC    = 1
) (
  input logic     CLK,
  input logic     nRST,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [1:0]       fcnt_r, fcnt_next_s;
  logic [LAT_W-1:0] cnt_r [NREGS];
  logic [NREGS-1:0] pend_s;
  logic [LAT_W-1:0] issue_lat_s;
  logic             freeze_s, stall_s, flush_s, fire_s, mark_s, redirect_s, src_hit_s;

  // Pending flags; entry 0 is held clear by the counter block.
  always_comb begin
    pend_s = {NREGS{1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      pend_s[r] = (cnt_r[r] != {LAT_W{1'b0}});
    end
  end

`ifdef FORWARD_EN
  assign issue_lat_s = hz.issue_is_load ? LAT_W'(LOAD_FWD_LAT) : {LAT_W{1'b0}};
`else
  assign issue_lat_s = hz.issue_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
`endif

  assign redirect_s = hz.branch_taken | hz.jump;
  assign freeze_s   = nRST & (hz.dmemREN | hz.dmemWEN) & ~hz.dhit;
  assign src_hit_s  = (hz.issue_rs_used & (hz.issue_rs != {REG_AW{1'b0}}) & pend_s[hz.issue_rs]) |
                      (hz.issue_rt_used & (hz.issue_rt != {REG_AW{1'b0}}) & pend_s[hz.issue_rt]);
  assign stall_s    = nRST & hz.issue_valid & (state_r != ST_FLUSH) & ~freeze_s & src_hit_s;
  assign fire_s     = hz.issue_valid & ~stall_s & ~freeze_s & (state_r != ST_FLUSH);
  assign mark_s     = fire_s & hz.issue_wen & (hz.issue_dest != {REG_AW{1'b0}});

  // Scoreboard counters: a new issue load beats the same-cycle decrement.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_r[r] <= {LAT_W{1'b0}};
      end
    end else begin
      cnt_r[0] <= {LAT_W{1'b0}};
      for (int r = 1; r < NREGS; r++) begin
        if (mark_s && (hz.issue_dest == REG_AW'(r))) begin
          cnt_r[r] <= issue_lat_s;
        end else if (!freeze_s && pend_s[r]) begin
          cnt_r[r] <= cnt_r[r] - LAT_W'(1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_RUN;
      fcnt_r  <= 2'd0;
    end else begin
      state_r <= state_next_s;
      fcnt_r  <= fcnt_next_s;
    end
  end

  // Next-state and flush decode; the redirect cycle itself already flushes.
  always_comb begin
    state_next_s = state_r;
    fcnt_next_s  = fcnt_r;
    flush_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (freeze_s) begin
          state_next_s = ST_MEMWAIT;
        end else if (redirect_s) begin
          state_next_s = ST_FLUSH;
          fcnt_next_s  = 2'(FLUSH_CYC);
          flush_s      = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (hz.dhit && redirect_s) begin
          state_next_s = ST_FLUSH;
          fcnt_next_s  = 2'(FLUSH_CYC);
          flush_s      = 1'b1;
        end else if (hz.dhit) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_MEMWAIT;
        end
      end
      ST_FLUSH: begin
        if (freeze_s) begin
          state_next_s = ST_FLUSH;
        end else if (redirect_s) begin
          fcnt_next_s  = 2'(FLUSH_CYC);
          flush_s      = 1'b1;
        end else if (fcnt_r <= 2'd1) begin
          state_next_s = ST_RUN;
          fcnt_next_s  = 2'd0;
          flush_s      = 1'b1;
        end else begin
          fcnt_next_s  = fcnt_r - 2'd1;
          flush_s      = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        fcnt_next_s  = 2'd0;
      end
    endcase
  end

  assign hz.stall  = stall_s;
  assign hz.flush  = flush_s & nRST;
  assign hz.freeze = freeze_s;
  assign hz.hazard = stall_s | (flush_s & nRST) | freeze_s;
  assign hz.state  = state_r;

endmodule
